// File: rtl/char_ram_pkg.sv
// Shared constants and state encoding for the character RAM write scheduler.
package char_ram_pkg;

    localparam int unsigned COLS       = 70;
    localparam int unsigned ROWS       = 30;
    localparam int unsigned CELLS      = COLS * ROWS;
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned DATA_W     = 7;
    localparam int unsigned FIFO_DEPTH = 4;

    localparam logic [DATA_W-1:0] BLANK_CHAR = 7'h00;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

endpackage

// File: rtl/hit_fifo.sv
// Small synchronous FIFO of pending hit-clear addresses.
// Flush empties it in one cycle; stored words are left as they are.
module hit_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_c,
    output logic             o_full_c,
    output logic             o_empty_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full_c  = (r_count == CNT_W'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_head_c  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full_c;
    assign w_pop  = i_pop && !o_empty_c;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/char_ram_wr_sched.sv
// Write-port scheduler for the 70x30 character RAM: arbitrates hit clears,
// letter spawns and a full-screen blanking sweep onto one registered write port.
module char_ram_wr_sched #(
    parameter int unsigned COLS       = char_ram_pkg::COLS,
    parameter int unsigned ROWS       = char_ram_pkg::ROWS,
    parameter int unsigned ADDR_W     = char_ram_pkg::ADDR_W,
    parameter int unsigned DATA_W     = char_ram_pkg::DATA_W,
    parameter int unsigned FIFO_DEPTH = char_ram_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_all_req,
    output logic              clr_all_busy,
    input  logic              hit_valid,
    input  logic [ADDR_W-1:0] hit_addr,
    output logic              hit_ready,
    input  logic              spawn_valid,
    input  logic [6:0]        spawn_col,
    input  logic [4:0]        spawn_row,
    input  logic [DATA_W-1:0] spawn_ascii,
    output logic              spawn_ready,
    output logic              spawn_err,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [7:0]        hit_count
);

    import char_ram_pkg::*;

    localparam int unsigned      N_CELLS   = COLS * ROWS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_CELLS - 1);
    localparam logic [7:0]        SCORE_MAX = 8'hFF;

    state_e            r_state;
    logic [ADDR_W-1:0] r_sweep_addr;
    logic              r_busy;
    logic              r_spawn_err;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [7:0]        r_hit_count;

    logic              w_idle;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [ADDR_W-1:0] w_fifo_head;
    logic              w_hit_fire;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_spawn_fire;
    logic              w_spawn_oor;
    logic [ADDR_W-1:0] w_spawn_addr;

    assign w_idle = (r_state == IDLE);

    // Ready handshakes are combinational so a requester sees acceptance in-cycle.
    assign hit_ready   = w_idle && !w_fifo_full;
    assign spawn_ready = w_idle && w_fifo_empty && !hit_valid && !clr_all_req;

    assign w_hit_fire   = hit_valid && hit_ready;
    assign w_push       = w_hit_fire && (hit_addr < ADDR_W'(N_CELLS));
    assign w_flush      = w_idle && clr_all_req;
    assign w_pop        = w_idle && !clr_all_req && !w_fifo_empty;
    assign w_spawn_fire = spawn_valid && spawn_ready;

    assign w_spawn_oor  = (spawn_col >= 7'(COLS)) || (spawn_row >= 5'(ROWS));
    assign w_spawn_addr = ADDR_W'(spawn_row) * ADDR_W'(COLS) + ADDR_W'(spawn_col);

    hit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W)
    ) u_hit_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .i_flush     (w_flush),
        .i_push      (w_push),
        .i_push_data (hit_addr),
        .i_pop       (w_pop),
        .o_head_c    (w_fifo_head),
        .o_full_c    (w_fifo_full),
        .o_empty_c   (w_fifo_empty)
    );

    // Scheduler FSM: pending hits beat spawns; a sweep owns the port for CELLS cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_sweep_addr <= '0;
            r_busy       <= 1'b0;
            r_spawn_err  <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_hit_count  <= '0;
        end else begin
            r_wr_en     <= 1'b0;
            r_spawn_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    if (clr_all_req) begin
                        r_state      <= SWEEP;
                        r_sweep_addr <= '0;
                        r_hit_count  <= '0;
                    end else if (w_pop) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_fifo_head;
                        r_wr_data <= DATA_W'(BLANK_CHAR);
                        if (r_hit_count != SCORE_MAX) begin
                            r_hit_count <= r_hit_count + 8'd1;
                        end
                    end else if (w_spawn_fire) begin
                        if (w_spawn_oor) begin
                            r_spawn_err <= 1'b1;
                        end else begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= w_spawn_addr;
                            r_wr_data <= spawn_ascii;
                        end
                    end
                end
                SWEEP: begin
                    r_busy    <= 1'b1;
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_sweep_addr;
                    r_wr_data <= DATA_W'(BLANK_CHAR);
                    if (r_sweep_addr == LAST_ADDR) begin
                        r_state <= IDLE;
                    end else begin
                        r_sweep_addr <= r_sweep_addr + ADDR_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign clr_all_busy = r_busy;
    assign spawn_err    = r_spawn_err;
    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign hit_count    = r_hit_count;

endmodule

// File: doc/char_ram_wr_sched.md
# char_ram_wr_sched

Write-port scheduler for the 70×30 character RAM that holds the falling letters of the typing game. Three requesters share the RAM's single write port: keystroke-hit clears, random-letter spawns and a full-screen blanking sweep. The block arbitrates them, converts spawn coordinates to linear addresses and keeps the hit score. It sits between the game logic (keyboard match, m-sequence spawner) and the RAM write port; the read side (VGA scan) is untouched.

## Interface
Parameters:
- COLS, 70, character columns per row
- ROWS, 30, character rows
- ADDR_W, 12, RAM address width
- DATA_W, 7, ASCII data width
- FIFO_DEPTH, 4, hit-request FIFO entries (power of two)

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- clr_all_req  in  1  one-cycle pulse: start blanking sweep
- clr_all_busy  out  1  sweep in progress
- hit_valid  in  1  hit-clear request
- hit_addr  in  ADDR_W  linear cell address to blank
- hit_ready  out  1  hit request accepted when hit_valid && hit_ready
- spawn_valid  in  1  spawn request
- spawn_col  in  7  column 0..COLS-1
- spawn_row  in  5  row 0..ROWS-1
- spawn_ascii  in  DATA_W  letter to write
- spawn_ready  out  1  spawn accepted when spawn_valid && spawn_ready
- spawn_err  out  1  one-cycle pulse: accepted spawn was out of range and was discarded
- wr_en, wr_addr, wr_data  out  1/ADDR_W/DATA_W  registered RAM write port
- hit_count  out  8  score: number of hit clears written

## Operation
- FSM states: IDLE and SWEEP. Reset puts the block in IDLE.
- IDLE → SWEEP when clr_all_req is high. On that transition the FIFO is flushed, hit_count is cleared and the sweep counter is set to 0.
- SWEEP writes data 0 to addresses 0..COLS*ROWS-1 (0..2099), one per cycle. After address 2099 is issued, the FSM returns to IDLE.
- clr_all_req during SWEEP is ignored; it does not restart the sweep.
- In SWEEP, hit_ready=0 and spawn_ready=0.
- In IDLE, the FIFO head has priority over spawn. Only one write is issued per cycle.
- hit_ready = IDLE && FIFO not full.
- Push and pop in the same cycle are allowed whenever the FIFO is not full. When the FIFO is full, hit_ready is low even if a pop happens that cycle.
- hit_addr ≥ 2100: accepted, not pushed, and no write is issued.
- spawn_ready = IDLE && FIFO empty && !hit_valid && !clr_all_req.
- Spawn address = spawn_row*COLS + spawn_col, computed in ADDR_W bits.
- spawn_col ≥ COLS or spawn_row ≥ ROWS: the spawn is accepted, no write is issued, and spawn_err pulses.
- hit_count increments on every hit write and saturates at 255.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, hit_count=0, clr_all_busy=0, spawn_err=0, FIFO empty. This gives hit_ready=1 and spawn_ready=1 after reset.
- Reset asserted mid-sweep aborts the sweep immediately. The RAM is left partly blanked; this is acceptable.

## Timing
- All outputs except hit_ready and spawn_ready are registered. hit_ready and spawn_ready are combinational from the state, the FIFO flags and the request inputs.
- Spawn: accepted at edge E0; wr_en/addr/data are valid in the cycle after E0 (1-cycle latency).
- Hit with FIFO empty: pushed at E0, popped at E1, write valid in the cycle after E1 (2-cycle latency).
- Sweep: clr_all_req sampled at E0; clr_all_busy=1 and the first write (address 0) are visible after E1.
  - Writes then run back-to-back for 2100 cycles.
  - clr_all_busy drops together with wr_en in the cycle after the address-2099 write.
- wr_en is high for exactly one cycle per write. wr_addr and wr_data hold their last value when wr_en=0.

## Structure
- Package char_ram_pkg: COLS, ROWS, CELLS (2100), ADDR_W, DATA_W, BLANK_CHAR (7'h00), and the state enum {IDLE, SWEEP}.
- Sub-module hit_fifo: synchronous FIFO, FIFO_DEPTH×ADDR_W, with async active-low reset and a flush input, providing full/empty flags.
- The top level contains the FSM, sweep counter, arbiter, coordinate multiply-add and score counter.

## Test plan
- After reset, one spawn (col 5, row 3, 'a'=7'h61) → one wr_en pulse with wr_addr=215, wr_data=7'h61, one cycle after acceptance.
- Hit (addr 140) and spawn asserted in the same cycle → spawn_ready=0; write of addr 140, data 0; hit_count=1; spawn accepted afterwards.
- Five back-to-back hits → hit_ready low while the FIFO is full; all accepted addresses written in order; hit_count=5.
- clr_all_req pulse → exactly 2100 writes, addresses 0..2099, data 0; busy high throughout; hit_count=0; a clr_all_req mid-sweep does not restart it.
- Spawn col=70 → spawn_err pulse, no write. hit_addr=2100 → no write, hit_count unchanged.
- reset asserted at sweep address 1000 → wr_en=0 and busy=0 immediately; next spawn proceeds normally.
